// File: rtl/qwic51_pkg.sv
// qwic51_pkg: shared source indices, vectors, SFR bit positions and FSM states
package qwic51_pkg;
  localparam int NUM_SRC = 5;
  localparam int IE_EA = 7;
  localparam int IE_ES = 4;
  localparam int IE_ET1 = 3;
  localparam int IE_EX1 = 2;
  localparam int IE_ET0 = 1;
  localparam int IE_EX0 = 0;
  localparam int IP_PS = 4;
  localparam int IP_PT1 = 3;
  localparam int IP_PX1 = 2;
  localparam int IP_PT0 = 1;
  localparam int IP_PX0 = 0;
  localparam logic [15:0] VEC_BASE = 16'h0003;
  typedef enum logic [2:0] {
    SRC_INT0 = 3'd0,
    SRC_TF0  = 3'd1,
    SRC_INT1 = 3'd2,
    SRC_TF1  = 3'd3,
    SRC_SER  = 3'd4
  } src_e;
  typedef enum logic {ST_IDLE, ST_REQ} state_e;
  // Vectors are spaced 8 bytes apart starting at 0x0003
  function automatic logic [15:0] vec_of(input src_e s);
    return VEC_BASE + {10'd0, s, 3'd0};
  endfunction
  // Lowest set index wins
  function automatic src_e first_src(input logic [NUM_SRC-1:0] m);
    first_src = SRC_INT0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (m[i]) first_src = src_e'(3'(i));
  endfunction
endpackage

// File: rtl/qwic51_intc_sync.sv
// qwic51_intc_sync: optional two-flop pin synchronizer with falling-edge detect
module qwic51_intc_sync #(
  parameter bit SYNC_EN = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_n,
  output logic sync_n,
  output logic fall
);
  logic s1, s2, prev;
  logic [2:0] vld;
  // Flops idle high; vld masks edges until the history holds real pin samples
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      prev <= 1'b1;
      vld <= '0;
    end else begin
      s1 <= pin_n;
      s2 <= s1;
      prev <= sync_n;
      vld <= {vld[1:0], 1'b1};
    end
  assign sync_n = SYNC_EN ? s2 : pin_n;
  assign fall = (SYNC_EN ? vld[2] : vld[0]) & prev & ~sync_n;
endmodule

// File: rtl/qwic51_intc.sv
// qwic51_intc: 8051-style five-source, two-level interrupt controller
module qwic51_intc
  import qwic51_pkg::*;
#(
  parameter bit SYNC_EN = 1'b1,
  parameter int CPU_DATA_WIDTH = 8,
  parameter int CPU_ROM_ADDWID = 16
) (
  input  logic                      CPU_CLK,
  input  logic                      CPU_RESET,
  input  logic                      INT0_N,
  input  logic                      INT1_N,
  input  logic                      TF0,
  input  logic                      TF1,
  input  logic                      RI_TI,
  input  logic [CPU_DATA_WIDTH-1:0] IE_REG,
  input  logic [CPU_DATA_WIDTH-1:0] IP_REG,
  input  logic [1:0]                TCON_IT,
  input  logic                      INST_BOUNDARY,
  input  logic                      IRQ_ACK,
  input  logic                      RETI,
  output logic                      IRQ_REQ,
  output logic [CPU_ROM_ADDWID-1:0] IRQ_VEC,
  output logic [1:0]                IE_FLAG,
  output logic [1:0]                TF_CLR,
  output logic [1:0]                ACTIVE_LVL
);
  state_e state;
  src_e src_q, sel;
  logic lvl_q, ack_ok, any_q;
  logic [1:0] sync_n, fall, clr, act_reti, act_nxt;
  logic [NUM_SRC-1:0] flags, en, pri, pend, hi_q, lo_q;
  logic unused_sfr;
  assign unused_sfr = ^{IE_REG, IP_REG};
  for (genvar i = 0; i < 2; i++) begin : g_sync
    qwic51_intc_sync #(.SYNC_EN(SYNC_EN)) u_sync (
      .clk(CPU_CLK),
      .rst(CPU_RESET),
      .pin_n(i == 0 ? INT0_N : INT1_N),
      .sync_n(sync_n[i]),
      .fall(fall[i])
    );
  end
  assign flags = {RI_TI, TF1, IE_FLAG[1], TF0, IE_FLAG[0]};
  assign en = {IE_REG[IE_ES], IE_REG[IE_ET1], IE_REG[IE_EX1], IE_REG[IE_ET0], IE_REG[IE_EX0]};
  assign pri = {IP_REG[IP_PS], IP_REG[IP_PT1], IP_REG[IP_PX1], IP_REG[IP_PT0], IP_REG[IP_PX0]};
  assign ack_ok = state == ST_REQ && IRQ_ACK;
  assign clr = {ack_ok && src_q == SRC_INT1, ack_ok && src_q == SRC_INT0};
  // Qualify against the in-service level and pick the winner
  always_comb begin
    pend = {NUM_SRC{IE_REG[IE_EA]}} & en & flags;
    hi_q = ACTIVE_LVL[1] ? '0 : pend & pri;
    lo_q = |ACTIVE_LVL ? '0 : pend & ~pri;
    any_q = |{hi_q, lo_q};
    sel = |hi_q ? first_src(hi_q) : first_src(lo_q);
  end
  // RETI retires the innermost level before a same-cycle ACK adds one
  always_comb begin
    act_reti = RETI ? (ACTIVE_LVL[1] ? {1'b0, ACTIVE_LVL[0]} : 2'b00) : ACTIVE_LVL;
    act_nxt = act_reti | (ack_ok ? (lvl_q ? 2'b10 : 2'b01) : 2'b00);
  end
  // IE flags: edge mode latches falls (a new fall beats the ACK clear), level mode follows the pin
  always_ff @(posedge CPU_CLK or posedge CPU_RESET)
    if (CPU_RESET) IE_FLAG <= '0;
    else IE_FLAG <= (TCON_IT & (fall | (IE_FLAG & ~clr))) | (~TCON_IT & ~sync_n);
  // Request FSM with latched vector/level, in-service tracking and timer clear pulses
  always_ff @(posedge CPU_CLK or posedge CPU_RESET)
    if (CPU_RESET) begin
      state <= ST_IDLE;
      IRQ_REQ <= 1'b0;
      IRQ_VEC <= '0;
      src_q <= SRC_INT0;
      lvl_q <= 1'b0;
      ACTIVE_LVL <= '0;
      TF_CLR <= '0;
    end else begin
      ACTIVE_LVL <= act_nxt;
      TF_CLR <= {ack_ok && src_q == SRC_TF1, ack_ok && src_q == SRC_TF0};
      if (state == ST_IDLE && INST_BOUNDARY && any_q) begin
        state <= ST_REQ;
        IRQ_REQ <= 1'b1;
        IRQ_VEC <= CPU_ROM_ADDWID'(vec_of(sel));
        src_q <= sel;
        lvl_q <= |hi_q;
      end else if (ack_ok) begin
        state <= ST_IDLE;
        IRQ_REQ <= 1'b0;
      end
    end
endmodule
